// File: rtl/sprite_pkg.sv
// Shared constants and state type for the sprite write-side loader.
package sprite_pkg;

   localparam logic [7:0] CMD_LOAD_PALETTE = 8'hA5;
   localparam logic [7:0] CMD_LOAD_IMAGE   = 8'h5A;

   localparam int PALETTE_DEPTH = 256;
   localparam int PALETTE_WIDTH = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PAL_HI,
      ST_PAL_LO,
      ST_IMG,
      ST_DONE
   } load_state_t;

   function automatic logic is_loading(input load_state_t s);
      return (s == ST_PAL_HI) || (s == ST_PAL_LO) || (s == ST_IMG);
   endfunction

endpackage

// File: rtl/sprite_loader_if.sv
// Byte stream in, sprite/palette RAM write ports and status out.
// Stream handshake: a byte moves on a rising clock edge where byte_valid_in and
// byte_ready_out are both high; the host keeps byte_in stable while valid is high.
interface sprite_loader_if
   import sprite_pkg::*;
#(
   parameter int AW = 16
);
   logic [7:0]               byte_in;
   logic                     byte_valid_in;
   logic                     byte_ready_out;
   logic [AW-1:0]            image_addr_out;
   logic [7:0]               image_data_out;
   logic                     image_we_out;
   logic [7:0]               palette_addr_out;
   logic [PALETTE_WIDTH-1:0] palette_data_out;
   logic                     palette_we_out;
   logic                     busy_out;
   logic                     done_out;
   logic                     error_out;

   modport slave (
      input  byte_in, byte_valid_in,
      output byte_ready_out,
      output image_addr_out, image_data_out, image_we_out,
      output palette_addr_out, palette_data_out, palette_we_out,
      output busy_out, done_out, error_out
   );

   modport master (
      output byte_in, byte_valid_in,
      input  byte_ready_out,
      input  image_addr_out, image_data_out, image_we_out,
      input  palette_addr_out, palette_data_out, palette_we_out,
      input  busy_out, done_out, error_out
   );
endinterface

// File: rtl/sprite_loader_timeout.sv
// Idle-cycle counter; expired is high on the cycle the TIMEOUT-th idle cycle ends.
module load_timeout #(
   parameter int TIMEOUT = 1048576
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + 1'b1;
      end
   end

   // A clear on the same cycle always wins over expiry.
   assign expired = enable && !clear && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/sprite_loader.sv
// Byte-stream command decoder that fills the sprite image and palette RAMs
// through registered single-cycle write strobes.
module sprite_loader
   import sprite_pkg::*;
#(
   parameter int WIDTH   = 256,
   parameter int HEIGHT  = 256,
   parameter int TIMEOUT = 1048576
) (
   input  logic            pixel_clk_in,
   input  logic            rst_n_in,
   sprite_loader_if.slave  bus
);
   localparam int PIXELS = WIDTH * HEIGHT;
   localparam int AW     = $clog2(PIXELS);
   localparam int PAW    = $clog2(PALETTE_DEPTH);

   load_state_t state, state_nxt;

   logic                     ready, busy, done;
   logic                     xfer;
   logic                     to_expired;
   logic [PAW-1:0]           pal_cnt;
   logic [AW-1:0]            img_cnt;
   logic [3:0]               red;
   logic                     pal_last, img_last;
   logic [AW-1:0]            img_addr_q;
   logic [7:0]               img_data_q;
   logic                     img_we_q;
   logic [PAW-1:0]           pal_addr_q;
   logic [PALETTE_WIDTH-1:0] pal_data_q;
   logic                     pal_we_q;
   logic                     err_q;

   assign xfer     = bus.byte_valid_in && ready;
   assign pal_last = (pal_cnt == PAW'(PALETTE_DEPTH - 1));
   assign img_last = (img_cnt == AW'(PIXELS - 1));

   load_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (pixel_clk_in),
      .rst_n   (rst_n_in),
      .clear   (xfer || !busy),
      .enable  (busy),
      .expired (to_expired)
   );

   always_ff @(posedge pixel_clk_in) begin
      if (!rst_n_in) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (xfer && bus.byte_in == CMD_LOAD_PALETTE) state_nxt = ST_PAL_HI;
            else if (xfer && bus.byte_in == CMD_LOAD_IMAGE) state_nxt = ST_IMG;
         end
         ST_PAL_HI: begin
            if (xfer)            state_nxt = ST_PAL_LO;
            else if (to_expired) state_nxt = ST_IDLE;
         end
         ST_PAL_LO: begin
            if (xfer)            state_nxt = pal_last ? ST_DONE : ST_PAL_HI;
            else if (to_expired) state_nxt = ST_IDLE;
         end
         ST_IMG: begin
            if (xfer && img_last) state_nxt = ST_DONE;
            else if (to_expired)  state_nxt = ST_IDLE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ready = (state != ST_DONE);
      busy  = is_loading(state);
      done  = (state == ST_DONE);
   end

   // Image counter is the raster address y*WIDTH + x, bytes arriving row by row.
   always_ff @(posedge pixel_clk_in) begin
      if (!rst_n_in) begin
         pal_cnt    <= '0;
         img_cnt    <= '0;
         red        <= '0;
         img_addr_q <= '0;
         img_data_q <= '0;
         img_we_q   <= 1'b0;
         pal_addr_q <= '0;
         pal_data_q <= '0;
         pal_we_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         img_we_q <= 1'b0;
         pal_we_q <= 1'b0;
         err_q    <= to_expired;
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  if (bus.byte_in == CMD_LOAD_PALETTE)    pal_cnt <= '0;
                  else if (bus.byte_in == CMD_LOAD_IMAGE) img_cnt <= '0;
                  else                                    err_q   <= 1'b1;
               end
            end
            ST_PAL_HI: begin
               if (xfer) red <= bus.byte_in[3:0];
            end
            ST_PAL_LO: begin
               if (xfer) begin
                  pal_we_q   <= 1'b1;
                  pal_addr_q <= pal_cnt;
                  pal_data_q <= {red, bus.byte_in};
                  if (!pal_last) pal_cnt <= pal_cnt + 1'b1;
               end
            end
            ST_IMG: begin
               if (xfer) begin
                  img_we_q   <= 1'b1;
                  img_addr_q <= img_cnt;
                  img_data_q <= bus.byte_in;
                  if (!img_last) img_cnt <= img_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.byte_ready_out   = ready;
   assign bus.busy_out         = busy;
   assign bus.done_out         = done;
   assign bus.error_out        = err_q;
   assign bus.image_addr_out   = img_addr_q;
   assign bus.image_data_out   = img_data_q;
   assign bus.image_we_out     = img_we_q;
   assign bus.palette_addr_out = pal_addr_q;
   assign bus.palette_data_out = pal_data_q;
   assign bus.palette_we_out   = pal_we_q;
endmodule

// File: tb/tb_sprite_loader.sv
// Bench for sprite_loader: command table, full palette/image loads, timeout and reset corners.
module tb_sprite_loader;
   import sprite_pkg::*;

   localparam int W  = 256;
   localparam int H  = 256;
   localparam int TO = 16;
   localparam int AW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sprite_loader_if #(.AW(AW)) bus ();

   sprite_loader #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(TO)) dut (
      .pixel_clk_in (clk),
      .rst_n_in     (rst_n),
      .bus          (bus)
   );

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   logic [55:0] img_q[$];
   logic [51:0] pal_q[$];
   int done_cnt = 0, err_cnt = 0, rdy_low_cnt = 0, img_wr_cnt = 0;
   int done_cyc = -1, err_cyc = -1, last_busy_cyc = -1;
   int last_acc = 0;

   typedef struct {
      logic [7:0] b;
      logic       exp_err;
      logic       exp_busy;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard and event monitor, sampled on the falling edge.
   always @(negedge clk) begin
      logic [55:0] ie;
      logic [51:0] pe;
      if (bus.image_we_out) begin
         img_wr_cnt++;
         if (img_q.size() == 0) begin
            n_total++;
            $display("FAIL img_unexpected_write: addr %0h data %0h with none expected",
                     bus.image_addr_out, bus.image_data_out);
         end else begin
            ie = img_q.pop_front();
            chk("img_write{cyc,addr,data}", {8'd0, 32'(cyc), bus.image_addr_out, bus.image_data_out},
                {8'd0, ie});
         end
      end
      if (bus.palette_we_out) begin
         if (pal_q.size() == 0) begin
            n_total++;
            $display("FAIL pal_unexpected_write: addr %0h data %0h with none expected",
                     bus.palette_addr_out, bus.palette_data_out);
         end else begin
            pe = pal_q.pop_front();
            chk("pal_write{cyc,addr,data}", {12'd0, 32'(cyc), bus.palette_addr_out, bus.palette_data_out},
                {12'd0, pe});
         end
      end
      if (bus.done_out) begin
         done_cnt++;
         done_cyc = cyc;
         chk("done_ready_low", bus.byte_ready_out, 0);
         chk("done_with_write", bus.image_we_out | bus.palette_we_out, 1);
      end
      if (!bus.byte_ready_out) rdy_low_cnt++;
      if (bus.error_out) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (bus.busy_out) last_busy_cyc = cyc;
   end

   // kind: 0 no write expected, 1 image write, 2 palette write.
   task automatic send(input logic [7:0] b, input int kind, input logic [15:0] ea, input logic [11:0] ed);
      int guard;
      logic [31:0] c1;
      guard = 0;
      bus.byte_in = b;
      bus.byte_valid_in = 1'b1;
      while (!bus.byte_ready_out && guard < 8) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.byte_ready_out) begin
         n_total++;
         $display("FAIL ready_wait: byte_ready_out got 0 expected 1");
      end else begin
         c1 = 32'(cyc + 1);
         if (kind == 1) img_q.push_back({c1, ea, ed[7:0]});
         if (kind == 2) pal_q.push_back({c1, ea[7:0], ed});
         last_acc = cyc + 1;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.byte_valid_in = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      bus.byte_valid_in = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"},    bus.byte_ready_out, 1);
      chk({tag, "_busy"},     bus.busy_out, 0);
      chk({tag, "_done"},     bus.done_out, 0);
      chk({tag, "_error"},    bus.error_out, 0);
      chk({tag, "_img_we"},   bus.image_we_out, 0);
      chk({tag, "_img_addr"}, bus.image_addr_out, 0);
      chk({tag, "_img_data"}, bus.image_data_out, 0);
      chk({tag, "_pal_we"},   bus.palette_we_out, 0);
      chk({tag, "_pal_addr"}, bus.palette_addr_out, 0);
      chk({tag, "_pal_data"}, bus.palette_data_out, 0);
   endtask

   initial begin
      #5_000_000;
      n_total++;
      $display("FAIL watchdog: time limit reached before the end of the test");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      int d0, e0, r0, w0, k, gap, t_last;

      vecs[0] = '{8'h33, 1'b1, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 1'b0};
      vecs[3] = '{8'hA4, 1'b1, 1'b0};
      vecs[4] = '{8'h5B, 1'b1, 1'b0};
      vecs[5] = '{8'hA5, 1'b0, 1'b1};
      vecs[6] = '{8'h5A, 1'b0, 1'b1};

      bus.byte_in = 8'h00;
      bus.byte_valid_in = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_reset_outputs("reset");

      // Single command bytes from IDLE.
      for (int i = 0; i < 7; i++) begin
         do_reset();
         send(vecs[i].b, 0, 16'd0, 12'd0);
         bus.byte_valid_in = 1'b0;
         chk("cmd_error", bus.error_out, vecs[i].exp_err);
         chk("cmd_busy", bus.busy_out, vecs[i].exp_busy);
         chk("cmd_ready", bus.byte_ready_out, 1);
         @(negedge clk);
         chk("cmd_error_one_cycle", bus.error_out, 0);
      end
      do_reset();

      // Full palette load.
      d0 = done_cnt; e0 = err_cnt; r0 = rdy_low_cnt;
      send(CMD_LOAD_PALETTE, 0, 16'd0, 12'd0);
      for (int n = 0; n < 256; n++) begin
         send(8'h0F, 0, 16'd0, 12'd0);
         send(n[7:0], 2, 16'(n), {4'hF, n[7:0]});
      end
      t_last = last_acc;
      idle(3);
      chk("pal_done_count", done_cnt - d0, 1);
      chk("pal_done_with_last_write", done_cyc, t_last);
      chk("pal_ready_low_cycles", rdy_low_cnt - r0, 1);
      chk("pal_no_error", err_cnt - e0, 0);
      chk("pal_pending", pal_q.size(), 0);
      chk("pal_busy_after", bus.busy_out, 0);

      // Full image load, valid held high.
      d0 = done_cnt; e0 = err_cnt; r0 = rdy_low_cnt; w0 = img_wr_cnt;
      send(CMD_LOAD_IMAGE, 0, 16'd0, 12'd0);
      for (int n = 0; n < W * H; n++) send(n[7:0], 1, n[15:0], {4'h0, n[7:0]});
      t_last = last_acc;
      idle(3);
      chk("img_done_count", done_cnt - d0, 1);
      chk("img_done_with_last_write", done_cyc, t_last);
      chk("img_ready_low_cycles", rdy_low_cnt - r0, 1);
      chk("img_write_count", img_wr_cnt - w0, W * H);
      chk("img_no_error", err_cnt - e0, 0);
      chk("img_pending", img_q.size(), 0);
      chk("img_busy_after", bus.busy_out, 0);

      // Bad command, then a palette load that starts normally and times out.
      e0 = err_cnt; d0 = done_cnt;
      send(8'h33, 0, 16'd0, 12'd0);
      chk("bad_cmd_error", bus.error_out, 1);
      chk("bad_cmd_busy", bus.busy_out, 0);
      send(CMD_LOAD_PALETTE, 0, 16'd0, 12'd0);
      for (int n = 0; n < 4; n++) begin
         send(8'h03, 0, 16'd0, 12'd0);
         send(8'h20 + 8'(n), 2, 16'(n), {4'h3, 8'h20 + 8'(n)});
      end
      idle(TO + 6);
      chk("bad_then_pal_errors", err_cnt - e0, 2);
      chk("bad_then_pal_no_done", done_cnt - d0, 0);
      chk("bad_then_pal_pending", pal_q.size(), 0);

      // Image load timeout, then a fresh load restarting at address 0.
      e0 = err_cnt;
      send(CMD_LOAD_IMAGE, 0, 16'd0, 12'd0);
      for (int n = 0; n < 10; n++) send(8'h40 + 8'(n), 1, 16'(n), {4'h0, 8'h40 + 8'(n)});
      t_last = last_acc;
      idle(TO + 9);
      chk("to_error_count", err_cnt - e0, 1);
      chk("to_error_cycle", err_cyc, t_last + TO);
      chk("to_busy_last_cycle", last_busy_cyc, t_last + TO - 1);
      chk("to_busy_after", bus.busy_out, 0);
      send(CMD_LOAD_IMAGE, 0, 16'd0, 12'd0);
      for (int n = 0; n < 3; n++) send(8'hC0 + 8'(n), 1, 16'(n), {4'h0, 8'hC0 + 8'(n)});
      idle(TO + 4);
      chk("restart_pending", img_q.size(), 0);
      chk("restart_timeout", err_cnt - e0, 2);

      // Reset in the middle of a palette entry.
      e0 = err_cnt; d0 = done_cnt;
      send(CMD_LOAD_PALETTE, 0, 16'd0, 12'd0);
      send(8'h0F, 0, 16'd0, 12'd0);
      idle(3);
      do_reset();
      check_reset_outputs("midload_reset");
      idle(TO + 4);
      chk("midload_no_error", err_cnt - e0, 0);
      chk("midload_no_done", done_cnt - d0, 0);
      chk("midload_pending", pal_q.size(), 0);

      // Random valid gaps during an image load.
      e0 = err_cnt; d0 = done_cnt; w0 = img_wr_cnt;
      send(CMD_LOAD_IMAGE, 0, 16'd0, 12'd0);
      k = 0;
      gap = 0;
      while (k < 300) begin
         if ($urandom_range(0, 1) == 1 || gap >= 6) begin
            send(k[7:0] ^ 8'h5A, 1, k[15:0], {4'h0, k[7:0] ^ 8'h5A});
            k++;
            gap = 0;
         end else begin
            bus.byte_valid_in = 1'b0;
            @(negedge clk);
            gap++;
         end
      end
      idle(TO + 4);
      chk("rand_write_count", img_wr_cnt - w0, 300);
      chk("rand_pending", img_q.size(), 0);
      chk("rand_timeout_only", err_cnt - e0, 1);
      chk("rand_no_done", done_cnt - d0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
